// File: rtl/inputs_debounce_edge_pkg.sv
// -----------------------------------------------------------------------------
// inputs_debounce_edge_pkg
// Common helpers shared by the debounce blocks: the legal range of the
// stable-sample count and the width of the per-bit counter that holds it.
// No ports; import with inputs_debounce_edge_pkg::*.
// -----------------------------------------------------------------------------
package inputs_debounce_edge_pkg;

    localparam int unsigned DEB_CYCLES_MIN = 1;
    localparam int unsigned DEB_CYCLES_MAX = 65535;

    // Counter width able to hold 0..n. Never returns 0, so an illegal n
    // still gives a sane width while the elaboration check reports it.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/inputs_debounce_edge_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
// One independent debounce channel: stable-sample counter, accepted level
// register and registered rise/fall pulses.
//   iClk    : rising-edge clock
//   iRst    : synchronous active-high reset
//   iSync   : synchronized input level
//   iFreeze : hold counter and level, suppress pulses
//   oLevel  : accepted (debounced) level
//   oRise   : one-cycle pulse, coincident with a new accepted 1
//   oFall   : one-cycle pulse, coincident with a new accepted 0
// -----------------------------------------------------------------------------
module debounce_bit
    import inputs_debounce_edge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        DEFAULT_OUT     = 1'b0,
    parameter int unsigned CW              = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iSync,
    input  logic iFreeze,
    output logic oLevel,
    output logic oRise,
    output logic oFall
);

    // Count value at which the next differing sample is accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (!iFreeze) begin
            if (iSync == lvl_q) begin
                // Any agreeing sample throws away the partial count.
                cnt_d = '0;
            end else if (cnt_q >= CNT_LAST) begin
                // N-th consecutive differing sample: accept it now, so the
                // pulse lands with the new level on the next cycle.
                lvl_d  = iSync;
                cnt_d  = '0;
                rise_d = iSync;
                fall_d = ~iSync;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q  <= '0;
            lvl_q  <= DEFAULT_OUT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign oLevel = lvl_q;
    assign oRise  = rise_q;
    assign oFall  = fall_q;

endmodule

// File: rtl/inputs_debounce_edge.sv
// -----------------------------------------------------------------------------
// inputs_debounce_edge
// SIZE independent debounce channels with edge pulses.
//   iClk        : rising-edge clock
//   iRst        : synchronous active-high reset
//   ivSync      : [SIZE] synchronized input levels
//   iFreeze     : hold all counters/levels, suppress pulses
//   ovDebounced : [SIZE] accepted levels
//   ovRise      : [SIZE] one-cycle pulse on accepted 0->1
//   ovFall      : [SIZE] one-cycle pulse on accepted 1->0
//   oAnyChange  : OR of all rise/fall pulses
// -----------------------------------------------------------------------------
module inputs_debounce_edge
    import inputs_debounce_edge_pkg::*;
#(
    parameter int unsigned SIZE            = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        DEFAULT_OUT     = 1'b0
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic [SIZE-1:0] ivSync,
    input  logic            iFreeze,
    output logic [SIZE-1:0] ovDebounced,
    output logic [SIZE-1:0] ovRise,
    output logic [SIZE-1:0] ovFall,
    output logic            oAnyChange
);

    generate
        if (DEBOUNCE_CYCLES < DEB_CYCLES_MIN || DEBOUNCE_CYCLES > DEB_CYCLES_MAX) begin : g_bad_cycles
            $error("inputs_debounce_edge: DEBOUNCE_CYCLES=%0d outside %0d..%0d",
                   DEBOUNCE_CYCLES, DEB_CYCLES_MIN, DEB_CYCLES_MAX);
        end
    endgenerate

    genvar g;
    generate
        for (g = 0; g < SIZE; g++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .DEFAULT_OUT     (DEFAULT_OUT)
            ) u_bit (
                .iClk    (iClk),
                .iRst    (iRst),
                .iSync   (ivSync[g]),
                .iFreeze (iFreeze),
                .oLevel  (ovDebounced[g]),
                .oRise   (ovRise[g]),
                .oFall   (ovFall[g])
            );
        end
    endgenerate

    assign oAnyChange = |(ovRise | ovFall);

endmodule
